// File: rtl/retire_multi.sv
// RETIRE_WIDTH-wide in-order commit stage: pops ready ROB head entries, serialises stores, raises flush on mispredict.
// Optional performance counters are enabled by defining RETIRE_PERF_CNT_EN.
module retire_multi #(
   parameter int RETIRE_WIDTH      = 2,
   parameter int PHY_RF_ADDR_WIDTH = 6,
   parameter int ARCH_ADDR_WIDTH   = 5,
   parameter int PC_WIDTH          = 32
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [RETIRE_WIDTH-1:0]                     rob_head_valid,
   input  logic [RETIRE_WIDTH-1:0]                     rob_head_ready,
   input  logic [RETIRE_WIDTH-1:0]                     rob_head_is_store,
   input  logic [RETIRE_WIDTH-1:0]                     rob_head_mispredict,
   input  logic [RETIRE_WIDTH-1:0]                     rob_head_has_dest,
   input  logic [RETIRE_WIDTH*ARCH_ADDR_WIDTH-1:0]     rob_head_arch_rd,
   input  logic [RETIRE_WIDTH*PHY_RF_ADDR_WIDTH-1:0]   rob_head_new_phy,
   input  logic [RETIRE_WIDTH*PHY_RF_ADDR_WIDTH-1:0]   rob_head_old_phy,
   input  logic [RETIRE_WIDTH*PC_WIDTH-1:0]            rob_head_target,
   input  logic [31:0]                                 st_addr_in,
   input  logic [31:0]                                 st_data_in,
   input  logic [3:0]                                  st_mask_in,
   output logic [$clog2(RETIRE_WIDTH+1)-1:0]           rob_pop_count,
   output logic [RETIRE_WIDTH-1:0]                     commit_en,
   output logic [RETIRE_WIDTH*ARCH_ADDR_WIDTH-1:0]     commit_arch_rd,
   output logic [RETIRE_WIDTH*PHY_RF_ADDR_WIDTH-1:0]   commit_phy,
   output logic [RETIRE_WIDTH-1:0]                     free_en,
   output logic [RETIRE_WIDTH*PHY_RF_ADDR_WIDTH-1:0]   free_phy,
   output logic [RETIRE_WIDTH-1:0]                     busy_table_wr_en,
   output logic                                        flush,
   output logic [PC_WIDTH-1:0]                         pc_to_jump,
   output logic [3:0]                                  dmem_wr_en_out,
   output logic [31:0]                                 dmem_addr_out,
   output logic [31:0]                                 dmem_data_out,
   input  logic                                        dmem_valid_in,
   output logic [31:0]                                 retired_count,
   output logic [15:0]                                 flush_count
);

   localparam int W     = RETIRE_WIDTH;
   localparam int A     = ARCH_ADDR_WIDTH;
   localparam int P     = PHY_RF_ADDR_WIDTH;
   localparam int CNT_W = $clog2(RETIRE_WIDTH + 1);

   typedef enum logic [1:0] {S_RUN, S_STORE, S_FLUSH} state_t;

   state_t state_reg, state_next;

   logic [W-1:0]        slot_ok;
   logic [W-1:0]        retire_chain;
   logic [W-1:0]        retire;
   logic [W-1:0]        keep;
   logic                store_start;
   logic                store_ack;
   logic                flush_hit;
   logic [PC_WIDTH-1:0] target_sel;
   logic [CNT_W-1:0]    pop_cnt;

   logic [W*A-1:0] commit_arch_next;
   logic [W*P-1:0] commit_phy_next;
   logic [W*P-1:0] free_phy_next;

   logic [W-1:0]        commit_en_reg;
   logic [W*A-1:0]      commit_arch_reg;
   logic [W*P-1:0]      commit_phy_reg;
   logic [W-1:0]        free_en_reg;
   logic [W*P-1:0]      free_phy_reg;
   logic [W-1:0]        busy_wr_reg;
   logic [PC_WIDTH-1:0] pc_to_jump_reg;
   logic [3:0]          dmem_wr_en_reg;
   logic [31:0]         st_addr_reg;
   logic [31:0]         st_data_reg;

   // A slot retires only if every older slot retires and none of them is a mispredicted branch.
   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_slot
         assign slot_ok[gi] = rob_head_valid[gi] & rob_head_ready[gi] & ~rob_head_is_store[gi];
         if (gi == 0) begin : g_first
            assign retire_chain[gi] = slot_ok[gi];
         end else begin : g_rest
            assign retire_chain[gi] = retire_chain[gi-1] & ~rob_head_mispredict[gi-1] & slot_ok[gi];
         end
         assign keep[gi] = retire[gi] & rob_head_has_dest[gi];
         assign commit_arch_next[gi*A +: A] = keep[gi] ? rob_head_arch_rd[gi*A +: A] : '0;
         assign commit_phy_next[gi*P +: P]  = keep[gi] ? rob_head_new_phy[gi*P +: P] : '0;
         assign free_phy_next[gi*P +: P]    = keep[gi] ? rob_head_old_phy[gi*P +: P] : '0;
      end
   endgenerate

   assign store_start = rob_head_valid[0] & rob_head_ready[0] & rob_head_is_store[0];
   assign flush_hit   = |(retire_chain & rob_head_mispredict);

   // At most one retired slot can be a mispredict, so a one-hot OR selects its target.
   always_comb begin
      target_sel = '0;
      for (int i = 0; i < W; i++) begin
         if (retire_chain[i] && rob_head_mispredict[i])
            target_sel = target_sel | rob_head_target[i*PC_WIDTH +: PC_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= S_RUN;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RUN: begin
            if (store_start)    state_next = S_STORE;
            else if (flush_hit) state_next = S_FLUSH;
         end
         S_STORE: if (dmem_valid_in) state_next = S_RUN;
         S_FLUSH: state_next = S_RUN;
         default: state_next = S_RUN;
      endcase
   end

   always_comb begin
      retire    = '0;
      store_ack = 1'b0;
      pop_cnt   = '0;
      case (state_reg)
         S_RUN:   retire    = retire_chain;
         S_STORE: store_ack = dmem_valid_in;
         default: ;
      endcase
      for (int i = 0; i < W; i++) pop_cnt = pop_cnt + CNT_W'(retire[i]);
      if (store_ack) pop_cnt = CNT_W'(1);
      rob_pop_count = rst ? pop_cnt : '0;
      flush         = (state_reg == S_FLUSH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         commit_en_reg   <= '0;
         commit_arch_reg <= '0;
         commit_phy_reg  <= '0;
         free_en_reg     <= '0;
         free_phy_reg    <= '0;
         busy_wr_reg     <= '0;
         pc_to_jump_reg  <= '0;
         dmem_wr_en_reg  <= '0;
         st_addr_reg     <= '0;
         st_data_reg     <= '0;
      end else begin
         commit_en_reg   <= keep;
         commit_arch_reg <= commit_arch_next;
         commit_phy_reg  <= commit_phy_next;
         free_en_reg     <= keep;
         free_phy_reg    <= free_phy_next;
         busy_wr_reg     <= keep;
         if (state_reg == S_RUN && state_next == S_FLUSH)
            pc_to_jump_reg <= target_sel;
         if (state_reg == S_RUN && store_start) begin
            st_addr_reg    <= st_addr_in;
            st_data_reg    <= st_data_in;
            dmem_wr_en_reg <= st_mask_in;
         end else if (store_ack) begin
            dmem_wr_en_reg <= '0;
         end
      end
   end

   assign commit_en        = commit_en_reg;
   assign commit_arch_rd   = commit_arch_reg;
   assign commit_phy       = commit_phy_reg;
   assign free_en          = free_en_reg;
   assign free_phy         = free_phy_reg;
   assign busy_table_wr_en = busy_wr_reg;
   assign pc_to_jump       = pc_to_jump_reg;
   assign dmem_wr_en_out   = dmem_wr_en_reg;
   assign dmem_addr_out    = st_addr_reg;
   assign dmem_data_out    = st_data_reg;

`ifdef RETIRE_PERF_CNT_EN
   logic [31:0] retired_cnt_reg;
   logic [15:0] flush_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired_cnt_reg <= '0;
         flush_cnt_reg   <= '0;
      end else begin
         retired_cnt_reg <= retired_cnt_reg + 32'(rob_pop_count);
         if (state_reg == S_RUN && state_next == S_FLUSH && flush_cnt_reg != 16'hFFFF)
            flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
   end

   assign retired_count = retired_cnt_reg;
   assign flush_count   = flush_cnt_reg;
`else
   assign retired_count = '0;
   assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_retire_multi.sv
// Directed self-checking bench for retire_multi at RETIRE_WIDTH=2 with hand-computed expectations.
module tb_retire_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  rob_head_valid, rob_head_ready, rob_head_is_store, rob_head_mispredict, rob_head_has_dest;
   logic [9:0]  rob_head_arch_rd;
   logic [11:0] rob_head_new_phy, rob_head_old_phy;
   logic [63:0] rob_head_target;
   logic [31:0] st_addr_in, st_data_in;
   logic [3:0]  st_mask_in;
   logic [1:0]  rob_pop_count;
   logic [1:0]  commit_en, free_en, busy_table_wr_en;
   logic [9:0]  commit_arch_rd;
   logic [11:0] commit_phy, free_phy;
   logic        flush;
   logic [31:0] pc_to_jump;
   logic [3:0]  dmem_wr_en_out;
   logic [31:0] dmem_addr_out, dmem_data_out;
   logic        dmem_valid_in;
   logic [31:0] retired_count;
   logic [15:0] flush_count;

   int checks   = 0;
   int failures = 0;

   retire_multi dut (
      .clk(clk), .rst(rst),
      .rob_head_valid(rob_head_valid), .rob_head_ready(rob_head_ready),
      .rob_head_is_store(rob_head_is_store), .rob_head_mispredict(rob_head_mispredict),
      .rob_head_has_dest(rob_head_has_dest), .rob_head_arch_rd(rob_head_arch_rd),
      .rob_head_new_phy(rob_head_new_phy), .rob_head_old_phy(rob_head_old_phy),
      .rob_head_target(rob_head_target),
      .st_addr_in(st_addr_in), .st_data_in(st_data_in), .st_mask_in(st_mask_in),
      .rob_pop_count(rob_pop_count), .commit_en(commit_en), .commit_arch_rd(commit_arch_rd),
      .commit_phy(commit_phy), .free_en(free_en), .free_phy(free_phy),
      .busy_table_wr_en(busy_table_wr_en), .flush(flush), .pc_to_jump(pc_to_jump),
      .dmem_wr_en_out(dmem_wr_en_out), .dmem_addr_out(dmem_addr_out), .dmem_data_out(dmem_data_out),
      .dmem_valid_in(dmem_valid_in), .retired_count(retired_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_slots();
      rob_head_valid = '0; rob_head_ready = '0; rob_head_is_store = '0;
      rob_head_mispredict = '0; rob_head_has_dest = '0; rob_head_arch_rd = '0;
      rob_head_new_phy = '0; rob_head_old_phy = '0; rob_head_target = '0;
   endtask

   task automatic set_slot(input int i, input logic v, r, st, mp, hd,
                           input logic [4:0] arch, input logic [5:0] np, op, input logic [31:0] tgt);
      rob_head_valid[i] = v; rob_head_ready[i] = r; rob_head_is_store[i] = st;
      rob_head_mispredict[i] = mp; rob_head_has_dest[i] = hd;
      rob_head_arch_rd[i*5 +: 5] = arch;
      rob_head_new_phy[i*6 +: 6] = np;
      rob_head_old_phy[i*6 +: 6] = op;
      rob_head_target[i*32 +: 32] = tgt;
   endtask

   initial begin
      rst = 1'b0;
      dmem_valid_in = 1'b0;
      st_addr_in = '0; st_data_in = '0; st_mask_in = '0;
      clear_slots();
      set_slot(0, 1, 1, 0, 0, 1, 5'd1, 6'd7, 6'd3, 32'h0);

      // Reset: outputs idle even with a ready head entry.
      #2;
      check("rst_pop", rob_pop_count, 0);
      check("rst_commit_en", commit_en, 0);
      check("rst_dmem_we", dmem_wr_en_out, 0);
      check("rst_flush", flush, 0);
      tick();
      check("rst_commit_en_edge", commit_en, 0);
      check("rst_pc", pc_to_jump, 0);
      rst = 1'b1;
      $display("txn reset done");

      // Dual retire.
      set_slot(0, 1, 1, 0, 0, 1, 5'd1, 6'd7, 6'd3, 32'h0);
      set_slot(1, 1, 1, 0, 0, 1, 5'd2, 6'd8, 6'd4, 32'h0);
      #1 check("dual_pop", rob_pop_count, 2);
      tick();
      clear_slots();
      check("dual_commit_en", commit_en, 2'b11);
      check("dual_arch", commit_arch_rd, {5'd2, 5'd1});
      check("dual_phy", commit_phy, {6'd8, 6'd7});
      check("dual_free_en", free_en, 2'b11);
      check("dual_free_phy", free_phy, {6'd4, 6'd3});
      check("dual_busy", busy_table_wr_en, 2'b11);
      $display("txn dual_retire done");

      // Partial: slot 1 not ready.
      set_slot(0, 1, 1, 0, 0, 1, 5'd5, 6'd11, 6'd12, 32'h0);
      set_slot(1, 1, 0, 0, 0, 1, 5'd6, 6'd13, 6'd14, 32'h0);
      #1 check("part_pop", rob_pop_count, 1);
      tick();
      clear_slots();
      check("part_commit_en", commit_en, 2'b01);
      check("part_busy", busy_table_wr_en, 2'b01);
      check("part_phy", commit_phy, {6'd0, 6'd11});
      $display("txn partial done");

      // No destination in slot 0: popped but no commit/free strobes.
      set_slot(0, 1, 1, 0, 0, 0, 5'd7, 6'd15, 6'd16, 32'h0);
      set_slot(1, 1, 1, 0, 0, 1, 5'd8, 6'd17, 6'd18, 32'h0);
      #1 check("nodest_pop", rob_pop_count, 2);
      tick();
      clear_slots();
      check("nodest_commit_en", commit_en, 2'b10);
      check("nodest_free_en", free_en, 2'b10);
      check("nodest_free_phy", free_phy, {6'd18, 6'd0});
      $display("txn no_dest done");

      // Empty slot 0 ends the group.
      set_slot(1, 1, 1, 0, 0, 1, 5'd9, 6'd19, 6'd20, 32'h0);
      #1 check("empty0_pop", rob_pop_count, 0);
      // Store at slot 1 ends the group at slot 0.
      set_slot(0, 1, 1, 0, 0, 1, 5'd9, 6'd19, 6'd20, 32'h0);
      set_slot(1, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h0);
      #1 check("store1_pop", rob_pop_count, 1);
      tick();
      clear_slots();
      check("store1_commit_en", commit_en, 2'b01);
      $display("txn group_end done");

      // Store at slot 0 with three wait cycles then accept.
      set_slot(0, 1, 1, 1, 0, 1, 5'd3, 6'd21, 6'd22, 32'h0);
      st_addr_in = 32'h100; st_data_in = 32'hDEAD; st_mask_in = 4'hF;
      #1 check("st_start_pop", rob_pop_count, 0);
      tick();
      st_addr_in = '0; st_data_in = '0; st_mask_in = '0;
      for (int c = 0; c < 3; c++) begin
         check("st_wait_we", dmem_wr_en_out, 4'hF);
         check("st_wait_pop", rob_pop_count, 0);
         tick();
      end
      dmem_valid_in = 1'b1;
      #1;
      check("st_acc_pop", rob_pop_count, 1);
      check("st_acc_we", dmem_wr_en_out, 4'hF);
      check("st_acc_addr", dmem_addr_out, 32'h100);
      check("st_acc_data", dmem_data_out, 32'hDEAD);
      tick();
      dmem_valid_in = 1'b0;
      clear_slots();
      check("st_done_we", dmem_wr_en_out, 0);
      check("st_done_commit_en", commit_en, 0);
      check("st_done_free_en", free_en, 0);
      set_slot(0, 1, 1, 0, 0, 1, 5'd1, 6'd1, 6'd2, 32'h0);
      #1 check("st_back_run_pop", rob_pop_count, 1);
      clear_slots();
      $display("txn store done");

      // Mispredict at slot 0 holds slot 1 until after the flush cycle.
      set_slot(0, 1, 1, 0, 1, 1, 5'd3, 6'd9, 6'd5, 32'h40);
      set_slot(1, 1, 1, 0, 0, 1, 5'd4, 6'd10, 6'd6, 32'h0);
      #1 check("mp0_pop", rob_pop_count, 1);
      tick();
      check("mp0_flush", flush, 1);
      check("mp0_pc", pc_to_jump, 32'h40);
      check("mp0_commit_en", commit_en, 2'b01);
      check("mp0_phy", commit_phy, {6'd0, 6'd9});
      clear_slots();
      set_slot(0, 1, 1, 0, 0, 1, 5'd4, 6'd10, 6'd6, 32'h0);
      #1 check("mp0_flush_pop", rob_pop_count, 0);
      tick();
      check("mp0_flush_end", flush, 0);
      check("mp0_after_pop", rob_pop_count, 1);
      tick();
      clear_slots();
      check("mp0_after_commit_en", commit_en, 2'b01);
      check("mp0_after_phy", commit_phy, {6'd0, 6'd10});

      // Mispredict at the last slot retires the whole group.
      set_slot(0, 1, 1, 0, 0, 1, 5'd1, 6'd7, 6'd3, 32'h0);
      set_slot(1, 1, 1, 0, 1, 1, 5'd2, 6'd8, 6'd4, 32'h80);
      #1 check("mp1_pop", rob_pop_count, 2);
      tick();
      clear_slots();
      check("mp1_flush", flush, 1);
      check("mp1_pc", pc_to_jump, 32'h80);
      check("mp1_commit_en", commit_en, 2'b11);
      tick();
      check("mp1_flush_end", flush, 0);
      $display("txn mispredict done");

      // Asynchronous reset in the middle of a store.
      set_slot(0, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h0);
      st_addr_in = 32'h200; st_data_in = 32'h55; st_mask_in = 4'h3;
      tick();
      check("ar_store_we", dmem_wr_en_out, 4'h3);
      #2;
      dmem_valid_in = 1'b1;
      rst = 1'b0;
      #1;
      check("ar_we_cleared", dmem_wr_en_out, 0);
      check("ar_pop", rob_pop_count, 0);
      dmem_valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("ar_run_pop", rob_pop_count, 0);
      tick();
      check("ar_reissue_we", dmem_wr_en_out, 4'h3);
      check("ar_reissue_addr", dmem_addr_out, 32'h200);
      dmem_valid_in = 1'b1;
      #1 check("ar_reissue_pop", rob_pop_count, 1);
      tick();
      dmem_valid_in = 1'b0;
      clear_slots();
      check("ar_done_we", dmem_wr_en_out, 0);
      $display("txn async_reset done");

      // Performance counters: three dual retires (the last one a mispredict) and one flush.
      rst = 1'b0;
      #1 rst = 1'b1;
      set_slot(0, 1, 1, 0, 0, 1, 5'd1, 6'd7, 6'd3, 32'h0);
      set_slot(1, 1, 1, 0, 0, 1, 5'd2, 6'd8, 6'd4, 32'h0);
      tick();
      tick();
      set_slot(1, 1, 1, 0, 1, 1, 5'd2, 6'd8, 6'd4, 32'h90);
      #1 check("perf_mp_pop", rob_pop_count, 2);
      tick();
      clear_slots();
      check("perf_flush", flush, 1);
      tick();
`ifdef RETIRE_PERF_CNT_EN
      check("perf_retired", retired_count, 6);
      check("perf_flushes", flush_count, 1);
`else
      check("perf_retired_off", retired_count, 0);
      check("perf_flushes_off", flush_count, 0);
`endif
      $display("txn perf_counters done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
